x25519_add: RTL and testbench
=============================

Name: x25519_add

Overview:
- Registered, fully pipelined wide-integer adder for the X25519 field-arithmetic datapath.
- Computes out = a + b on unreduced 264-bit operands; no modular reduction (the downstream multiply/reduce stage handles that).
- Accepts one operation per clock; result appears with a single-cycle valid strobe.

Parameters:
- WIDTH, 264, operand/result width in bits. Holds a 256-bit field element plus 8 guard bits for carries. Only 264 is verified.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  operation request; a, b are sampled on the rising edge where en=1.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- out_valid  output  1  one-cycle strobe marking the result of one en.
- out  output  WIDTH  registered sum.

Behaviour:
- Reset (rst_n low, asynchronous assert): out_valid=0, out=0. Deassertion is synchronised externally. Reset mid-operation discards the in-flight result; no valid strobe follows for that operation.
- Arithmetic: out = (a + b) mod 2^WIDTH, unsigned. Carry out of bit WIDTH-1 is discarded; no saturation or error flag.
  - 256-bit operands can never overflow 264 bits. Bit 256 holds the carry, e.g. 0x01635e... for two ~2^256 inputs.
- Latency: exactly 1 cycle.
  - Rising edge N samples en=1 with a, b.
  - After edge N: out holds a+b and out_valid=1.
- Throughput: 1 op/cycle, no backpressure. en may be high on consecutive cycles; each cycle's result follows one cycle later, in order.
- out_valid: registered copy of en. High for exactly one cycle per accepted op; low after any cycle with en=0.
- out hold rule: updates only on cycles where en=1. Otherwise it keeps the last sum; reset value is 0 before the first op.
- No internal state machine beyond the output/valid registers.
- a and b are don't-care when en=0; X on them must not propagate to out.
- Implementation: generic carry chain built as 33 byte-wide limbs with ripple/lookahead carry. A single `+` is acceptable if it meets timing.

Optional Feature:
- Macro X25519_ADD_PIPE_EN.
- Defined: adder split into two pipeline stages.
  - Stage 1 adds the low 132 bits and registers the carry, the high operand halves, and en.
  - Stage 2 adds the high 132 bits plus the carry.
  - Latency 2 cycles, throughput unchanged at 1/cycle.
  - Reset clears both stages' valid and data.
  - out_valid and the hold rule apply at stage 2.
- Undefined (default): single-stage behaviour above, latency 1. All bench expectations below assume the default.

Test Plan:
- Reset, then idle: rst_n low, en=0 -> out_valid=0, out=0. With rst_n high and en still 0, both stay 0.
- Single op:
  - a=dc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967
  - b=873d418211b4c6b2d4e9175d5a58b7329a9f635a8de8f8c246fbabcdecff73c6
  - -> one cycle later out_valid=1, out=01635eb5906650945e33411c82fd89c49963d291d175044d3f2aee65f73750dd2d
- Back-to-back, en high 5 consecutive cycles:
  - Operations, in issue order:
    - f1b10fa85c89be757c05d1fbaafbfe02dbec3c323bec5c8f6bea7e3efc413e70 + b3eb9599bbf961d8943ce6293afa431a5c1854affbb02a3896dc970167e1a1e9
    - 7dba22bb1548e333af1bacaa0911643b795e5a14641c1e1f6448cbca3ae9f705 + f59b196f5c4750cd3b10f2d4dc9e2470634bc573c57ba823bd47d00be5a100ef
    - 4efd154fe4e2b3365c3bb5be55aa21ac6cfa4ebc3d7938984eb51bf8f87f1a0b + a98249329ef0af94d3047370a21a2b8605cb775f344de032e8ca13a429231ce1
    - 86200bf407fb8520304a1cde76ad7fa3afc4e5092d4cf3aca80ebc9a548ad408 + c3bab9ec04b26c23f6c4ec3247d42d84cd3306429bd78e5b4418d50a4829b270
  - -> out_valid high on consecutive cycles. Results in order:
    - 01a59ca5421883204e1042b824e5f6411d380490e2379c86c802c715406422e059
    - 0173553c2a71903400ea2c9f7ee5af88abdcaa1f882997c64321909bd6208af7f4
    - 00f87f5e8283d362cb2f40292ef7c44d3272c5c61b71c718cb377f2f9d21a236ec
    - 0149dac5e00cadf144270f0910be81ad287cf7eb4bc9248207ec2791a49cb48678
- Hold: en drops after an op -> out_valid=0 next cycle; out keeps last sum while a, b change.
- Wrap and carry chain:
  - a=all-ones(264), b=1 -> out=0, out_valid=1.
  - a=0x00ff..ff(256 ones), b=1 -> out=1<<256.
- Reset mid-stream: rst_n asserted the cycle after en=1 -> out_valid and out forced to 0 immediately; no strobe after release.

Source files
------------

// File: rtl/x25519_add.sv
// x25519_add: registered wide-integer adder for the X25519 field datapath.
// Computes out = (a + b) mod 2^WIDTH on unreduced operands. No modular
// reduction is done here.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         operation request; a, b are sampled on the edge where en=1
//   a, b       unsigned addends, WIDTH bits
//   out_valid  one-cycle strobe for each accepted operation
//   out        registered sum; holds its value between operations
//
// Build option:
//   X25519_ADD_PIPE_EN  When defined, the adder is split into two register
//                       stages and latency becomes 2 cycles. When undefined
//                       (the default), there is a single stage with
//                       latency 1. Throughput is 1 op/cycle in both builds.
module x25519_add #(
  parameter int unsigned WIDTH = 264
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out
);

`ifdef X25519_ADD_PIPE_EN

  localparam int unsigned LO_W = WIDTH / 2;
  localparam int unsigned HI_W = WIDTH - LO_W;

  logic [LO_W:0]   lo_sum_c;
  logic [HI_W-1:0] hi_sum_c;

  logic            v1_q;
  logic            c1_q;
  logic [LO_W-1:0] lo_q;
  logic [HI_W-1:0] ahi_q;
  logic [HI_W-1:0] bhi_q;

  // Low half sum; bit LO_W is the carry into the high half.
  assign lo_sum_c = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};

  // High half sum plus the registered carry. The final carry is dropped.
  assign hi_sum_c = ahi_q + bhi_q + HI_W'(c1_q);

  // Stage 1: register the low sum, the carry and the high operand halves.
  // Data only loads on en, so X on idle inputs never enters the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      c1_q  <= 1'b0;
      lo_q  <= '0;
      ahi_q <= '0;
      bhi_q <= '0;
    end else begin
      v1_q <= en;
      if (en) begin
        c1_q  <= lo_sum_c[LO_W];
        lo_q  <= lo_sum_c[LO_W-1:0];
        ahi_q <= a[WIDTH-1:LO_W];
        bhi_q <= b[WIDTH-1:LO_W];
      end
    end
  end

  // Stage 2: join the halves. out holds its value when no op arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        out <= {hi_sum_c, lo_q};
      end
    end
  end

`else

  localparam int unsigned NLIMB = WIDTH / 8;

  logic [WIDTH-1:0] sum_c;

  // Byte-wide ripple carry chain across all limbs. The top carry is dropped.
  always_comb begin : limb_chain
    logic carry;
    carry = 1'b0;
    sum_c = '0;
    for (int i = 0; i < int'(NLIMB); i++) begin
      {carry, sum_c[i*8 +: 8]} = 9'(a[i*8 +: 8]) + 9'(b[i*8 +: 8]) + 9'(carry);
    end
  end

  // Output registers. The sum only loads on en, so out holds between ops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= en;
      if (en) begin
        out <= sum_c;
      end
    end
  end

`endif

endmodule

// File: tb/tb_x25519_add.sv
// Directed, self-checking bench for x25519_add. Expected sums are pushed to a
// scoreboard queue when an operation is driven. They are popped and compared
// when out_valid is expected.
module tb_x25519_add;

  localparam int unsigned W = 264;
`ifdef X25519_ADD_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W-1:0] out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sq[$];   // expected sums, in issue order
  logic         vq[$];   // expected valid, delayed by LAT
  logic [W-1:0] last_out;

  x25519_add #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_reset();
    sq.delete();
    vq.delete();
    for (int i = 1; i < int'(LAT); i++) vq.push_back(1'b0);
    last_out = '0;
  endtask

  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] exp);
    en = 1'b1;
    a  = x;
    b  = y;
    sq.push_back(exp);
  endtask

  task automatic drive_idle(input logic [W-1:0] x, input logic [W-1:0] y);
    en = 1'b0;
    a  = x;
    b  = y;
  endtask

  // Advance one edge and check the output 1 time unit after it.
  // A valid cycle pops the scoreboard. An idle cycle checks the hold rule.
  task automatic tick(input string tag);
    logic         ev;
    logic [W-1:0] es;
    @(posedge clk);
    vq.push_back(en);
    ev = vq.pop_front();
    #1;
    chk_bit({tag, "_valid"}, out_valid, ev);
    if (ev) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s_sb observed=valid expected=empty_scoreboard", tag);
      end else begin
        es = sq.pop_front();
        chk_vec({tag, "_out"}, out, es);
        last_out = es;
      end
    end else begin
      chk_vec({tag, "_hold"}, out, last_out);
    end
  endtask

  logic [W-1:0] ones264;
  logic [W-1:0] ones256;
  logic [W-1:0] r1;
  logic [W-1:0] r2;

  initial begin
    ones264 = '1;
    ones256 = {8'h00, {32{8'hff}}};

    // Reset with idle inputs.
    rst_n = 1'b0;
    drive_idle('x, 'x);
    sb_reset();
    #1;
    chk_bit("reset_valid", out_valid, 1'b0);
    chk_vec("reset_out", out, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after release, with X on the operands.
    tick("idle0");
    tick("idle1");

    // Single op.
    drive_op(264'hdc21740e549bcdab5e580525a3310d66c9332e76e71b547ce3f2ba294a516967,
             264'h873d418211b4c6b2d4e9175d5a58b7329a9f635a8de8f8c246fbabcdecff73c6,
             264'h01635eb5906650945e33411c82fd89c49963d291d175044d3f2aee65f73750dd2d);
    tick("single_issue");
    drive_idle('x, 'x);
    for (int i = 1; i < int'(LAT); i++) tick("single_wait");
    tick("single_after");

    // Back-to-back ops: en is high for 5 consecutive cycles.
    drive_op(264'hf1b10fa85c89be757c05d1fbaafbfe02dbec3c323bec5c8f6bea7e3efc413e70,
             264'hb3eb9599bbf961d8943ce6293afa431a5c1854affbb02a3896dc970167e1a1e9,
             264'h01a59ca5421883204e1042b824e5f6411d380490e2379c86c802c715406422e059);
    tick("b2b0");
    drive_op(264'h7dba22bb1548e333af1bacaa0911643b795e5a14641c1e1f6448cbca3ae9f705,
             264'hf59b196f5c4750cd3b10f2d4dc9e2470634bc573c57ba823bd47d00be5a100ef,
             264'h0173553c2a71903400ea2c9f7ee5af88abdcaa1f882997c64321909bd6208af7f4);
    tick("b2b1");
    drive_op(264'h4efd154fe4e2b3365c3bb5be55aa21ac6cfa4ebc3d7938984eb51bf8f87f1a0b,
             264'ha98249329ef0af94d3047370a21a2b8605cb775f344de032e8ca13a429231ce1,
             264'h00f87f5e8283d362cb2f40292ef7c44d3272c5c61b71c718cb377f2f9d21a236ec);
    tick("b2b2");
    drive_op(264'h86200bf407fb8520304a1cde76ad7fa3afc4e5092d4cf3aca80ebc9a548ad408,
             264'hc3bab9ec04b26c23f6c4ec3247d42d84cd3306429bd78e5b4418d50a4829b270,
             264'h0149dac5e00cadf144270f0910be81ad287cf7eb4bc9248207ec2791a49cb48678);
    tick("b2b3");
    // (2^256 - 1) * 2 = 2^257 - 2.
    drive_op(ones256, ones256, {8'h01, {31{8'hff}}, 8'hfe});
    tick("b2b4");

    // Hold: the operands change while en is low.
    r1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    r2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    drive_idle(r1, r2);
    for (int i = 1; i < int'(LAT); i++) tick("b2b_drain");
    tick("hold0");
    drive_idle(r2, r1);
    tick("hold1");

    // Wrap from all-ones, then a carry that ripples through 256 bits.
    drive_op(ones264, 264'd1, '0);
    tick("wrap_issue");
    drive_op(ones256, 264'd1, 264'd1 << 256);
    tick("carry_issue");
    drive_idle('x, 'x);
    for (int i = 1; i < int'(LAT); i++) tick("carry_wait");
    tick("carry_after");

    // Reset mid-stream: assert rst_n the cycle after en=1.
    drive_op(r1, r2, r1 + r2);
    tick("rst_issue");
    drive_idle('x, 'x);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("rst_async_valid", out_valid, 1'b0);
    chk_vec("rst_async_out", out, '0);
    sb_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
